// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// Grant indices are 2 bits wide, so one grant can address up to four requesters.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set bit of full,
// searching last+1, last+2, ... with wrap-around.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] full,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant,
  output logic            found
);

  logic [ID_W-1:0] cand [NREQ];

  // cand[gi] is the slot examined at search distance gi+1 from last
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum      = {1'b0, last} + (ID_W+1)'(gi + 1);
      assign cand[gi] = ID_W'((sum >= (ID_W+1)'(NREQ)) ? sum - (ID_W+1)'(NREQ) : sum);
    end
  endgenerate

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (full[cand[k]]) begin
        grant = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit serializer between NREQ one-byte holding slots,
// granting round-robin and supervising the serializer busy handshake.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int START_TO = 16,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [ID_W-1:0]        grant_id,
  input  logic                   err_clr,
  output logic                   err_timeout,
  output logic [CNT_W-1:0]       sent_count
);

  localparam int TO_W = $clog2(START_TO + 1);

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   full_reg, full_next, load_en;
  logic [BYTE_W-1:0] slot_reg [NREQ];
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   last_reg, last_next;
  logic [BYTE_W-1:0] data_reg, data_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  sent_reg, sent_next;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;
  logic [BYTE_W-1:0] pick_data;
  logic              clear_en;

  uart_tx_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .full  (full_reg),
    .last  (last_reg),
    .grant (pick_id),
    .found (pick_found)
  );

  assign load_en = req_valid & ~full_reg;

  // Only the granted slot is ever cleared, and a granted slot is full, so
  // load and clear never target the same slot in the same cycle.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      assign full_next[gi] = (clear_en && (grant_reg == ID_W'(gi))) ? 1'b0 :
                             (load_en[gi] ? 1'b1 : full_reg[gi]);
    end
  endgenerate

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == ID_W'(i)) pick_data = slot_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    to_next    = to_reg;
    sent_next  = sent_reg;
    err_next   = err_reg & ~err_clr;
    clear_en   = 1'b0;
    tx_start   = 1'b0;

    case (state_reg)
      IDLE: begin
        // A busy serializer in IDLE belongs to someone else; wait it out.
        if (pick_found && !tx_busy) begin
          grant_next = pick_id;
          data_next  = pick_data;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        tx_start   = 1'b1;
        to_next    = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          to_next = to_reg + TO_W'(1);
          if (to_next == TO_W'(START_TO)) begin
            err_next   = 1'b1;
            clear_en   = 1'b1;
            last_next  = grant_reg;
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          clear_en   = 1'b1;
          last_next  = grant_reg;
          sent_next  = sent_reg + CNT_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      full_reg  <= '0;
      for (int i = 0; i < NREQ; i++) slot_reg[i] <= '0;
      grant_reg <= '0;
      data_reg  <= '0;
      last_reg  <= ID_W'(NREQ - 1);
      to_reg    <= '0;
      err_reg   <= 1'b0;
      sent_reg  <= '0;
    end else begin
      state_reg <= state_next;
      full_reg  <= full_next;
      for (int i = 0; i < NREQ; i++) begin
        if (load_en[i]) slot_reg[i] <= req_data[BYTE_W*i +: BYTE_W];
      end
      grant_reg <= grant_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      to_reg    <= to_next;
      err_reg   <= err_next;
      sent_reg  <= sent_next;
    end
  end

  assign req_ready   = ~full_reg;
  assign tx_data     = data_reg;
  assign grant_id    = grant_reg;
  assign err_timeout = err_reg;
  assign sent_count  = sent_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a busy-responder model drives tx_busy
// and a scoreboard queue holds the expected {grant_id, tx_data} per tx_start.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int START_TO  = 16;
  localparam int CNT_W     = 4;
  localparam int M_RESPOND = 0;
  localparam int M_NEVER   = 1;
  localparam int M_FOREIGN = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]  req_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic [1:0]       grant_id;
  logic             err_clr = 1'b0;
  logic             err_timeout;
  logic [CNT_W-1:0] sent_count;

  int passed = 0;
  int total = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  int mode = M_RESPOND;
  int busy_len = 20;
  int busy_left = 0;
  int start_cnt = 0;
  logic have_cur = 1'b0;
  logic [7:0] cur_data = '0;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .START_TO (START_TO),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .err_clr     (err_clr),
    .err_timeout (err_timeout),
    .sent_count  (sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serializer model: busy rises the cycle after tx_start and lasts busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_busy   = 1'b0;
        busy_left = 0;
      end else begin
        if (mode == M_FOREIGN) tx_busy = 1'b1;
        else if (busy_left > 0) begin
          tx_busy = 1'b1;
          busy_left--;
        end else tx_busy = 1'b0;
        if (mode == M_RESPOND && tx_start) busy_left = busy_len;
      end
    end
  end

  // Output monitor: every tx_start pops one expected {grant_id, tx_data}.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        start_cnt++;
        if (exp_q.size() == 0) chk("spurious_start", {31'b0, tx_start}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e[7:0]);
          chk("grant_id", grant_id, e[9:8]);
        end
        cur_data = tx_data;
        have_cur = 1'b1;
      end else if (rst_n && tx_busy && have_cur && mode == M_RESPOND) begin
        chk("tx_data_stable", tx_data, cur_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    @(negedge clk);
    chk("ready_for_load", req_ready & v, v);
    req_valid = v;
    req_data  = d;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_sent(input string tag, input int exp, input int budget);
    logic [CNT_W-1:0] expv;
    int n;
    expv = CNT_W'(exp);
    n = 0;
    while (sent_count !== expv && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sent_count, expv);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tx_start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    err_clr = 1'b0;
    exp_q.delete();
    have_cur = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_to_err(input string tag, output int cnt);
    cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (err_timeout === 1'b1 || cnt >= 40) break;
      @(posedge clk);
      cnt++;
    end
    chk(tag, cnt, START_TO);
  endtask

  initial begin
    int lat, n, cnt, s0;
    logic [7:0] b;
    logic [1:0] idx;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_sent", sent_count, 0);
    chk("rst_ready", req_ready, 4'hF);
    rst_n = 1'b1;

    // Single request on slot 2
    @(negedge clk);
    exp_q.push_back({2'd2, 8'h5A});
    req_valid = 4'b0100;
    req_data  = 32'h005A_0000;
    lat = 0;
    while (tx_start !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      req_valid = '0;
    end
    chk("single_latency", lat, 2);
    chk("single_ready_low", req_ready, 4'b1011);
    wait_sent("single_sent", 1, 60);
    chk("single_ready_back", req_ready, 4'hF);

    // Round-robin: all four at once, then slot 3 followed by slot 0
    do_reset();
    chk("rr_sent_cleared", sent_count, 0);
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    drive(4'hF, 32'h1312_1110);
    wait_sent("rr_batch_sent", 4, 200);
    @(negedge clk);
    exp_q.push_back({2'd3, 8'h23});
    req_valid = 4'b1000;
    req_data  = 32'h2300_0000;
    @(negedge clk);
    exp_q.push_back({2'd0, 8'h20});
    req_valid = 4'b0001;
    req_data  = 32'h0000_0020;
    @(negedge clk);
    req_valid = '0;
    wait_sent("rr_reload_sent", 6, 120);

    // Timeout: serializer never answers
    mode = M_NEVER;
    exp_q.push_back({2'd1, 8'h77});
    drive(4'b0010, 32'h0000_7700);
    wait_start("to_start");
    count_to_err("timeout_cycles", cnt);
    chk("timeout_ready", req_ready, 4'hF);
    chk("timeout_sent", sent_count, 6);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err_timeout, 0);

    // Timeout while err_clr is held: the set must win on that edge
    err_clr = 1'b1;
    exp_q.push_back({2'd0, 8'h78});
    drive(4'b0001, 32'h0000_0078);
    wait_start("to2_start");
    count_to_err("set_wins_cycles", cnt);
    chk("set_wins", err_timeout, 1);
    @(negedge clk);
    chk("clr_after_set", err_timeout, 0);
    err_clr = 1'b0;

    // Foreign busy holds off slot 1
    mode = M_FOREIGN;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    exp_q.push_back({2'd1, 8'h31});
    drive(4'b0010, 32'h0000_3100);
    repeat (10) @(negedge clk);
    chk("foreign_no_start", start_cnt, s0);
    chk("foreign_slot_held", req_ready, 4'b1101);
    mode = M_RESPOND;
    @(posedge clk);
    #2;
    chk("foreign_busy_dropped", tx_busy, 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 || n >= 10) break;
      @(posedge clk);
      n++;
    end
    chk("foreign_turnaround", {31'b0, (n >= 1 && n <= 2)}, 1);
    wait_sent("foreign_sent", 7, 60);

    // Reset during WAIT_DONE with slots 0 and 1 pending
    exp_q.push_back({2'd2, 8'h44});
    drive(4'b0100, 32'h0044_0000);
    wait_start("mid_start");
    repeat (5) @(negedge clk);
    chk("mid_busy", tx_busy, 1);
    drive(4'b0011, 32'h0000_4241);
    chk("mid_ready_before", req_ready, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_ready", req_ready, 4'hF);
    chk("mid_rst_sent", sent_count, 0);
    repeat (2) @(negedge clk);
    have_cur = 1'b0;
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    chk("mid_no_spurious", start_cnt, s0);

    // Counter wrap with 4-bit sent_count
    busy_len = 3;
    for (int i = 1; i <= 17; i++) begin
      idx = 2'(i % 4);
      b   = 8'(8'h80 + i);
      exp_q.push_back({idx, b});
      drive(4'b0001 << idx, {24'b0, b} << (8 * idx));
      wait_sent($sformatf("wrap_frame_%0d", i), i % 16, 40);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
